// File: rtl/cdc_bus_sync_rx_if.sv
// Handshake bundle between the toggle-CDC source side, the receiver
// and its dest_clk-domain consumer.
interface cdc_bus_sync_rx_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    logic              src_req_tgl;
    logic [DATA_W-1:0] src_data;
    logic              dest_ack_tgl;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              busy;
    logic              proto_err;
    logic [CNT_W-1:0]  xfer_cnt;

    modport master (
        output src_req_tgl, src_data, dout_ready,
        input  dest_ack_tgl, dout, dout_valid,
        input  busy, proto_err, xfer_cnt
    );

    modport slave (
        input  src_req_tgl, src_data, dout_ready,
        output dest_ack_tgl, dout, dout_valid,
        output busy, proto_err, xfer_cnt
    );
endinterface

// File: rtl/cdc_bus_sync_rx.sv
// Destination side of a toggle request/ack multi-bit CDC handshake:
// synchronises the request, captures the held bus, returns an ack toggle.
module cdc_bus_sync_rx #(
    parameter int DATA_W       = 8,
    parameter int NUM_OF_FLOPS = 2,
    parameter int CNT_W        = 16
) (
    input  logic               dest_clk,
    input  logic               rstn,
    cdc_bus_sync_rx_if.slave   bus
);
    typedef enum logic {IDLE, VALID} state_t;

    state_t              state, state_n;
    logic [NUM_OF_FLOPS-1:0] sync;
    logic                req_sync;
    logic                req_prev, req_prev_n;
    logic                req_pend;
    logic                ack, ack_n;
    logic [DATA_W-1:0]   dout, dout_n;
    logic                valid, valid_n;
    logic                busy, busy_n;
    logic                err, err_n;
    logic [CNT_W-1:0]    cnt, cnt_n;

    // Plain flop chain; src_data is deliberately never synchronised.
    always_ff @(posedge dest_clk or negedge rstn) begin
        if (!rstn) begin
            sync <= '0;
        end else begin
            sync <= {sync[NUM_OF_FLOPS-2:0], bus.src_req_tgl};
        end
    end

    assign req_sync = sync[NUM_OF_FLOPS-1];
    assign req_pend = req_sync ^ req_prev;

    always_ff @(posedge dest_clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            req_prev <= 1'b0;
            ack      <= 1'b0;
            dout     <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
            cnt      <= '0;
        end else begin
            state    <= state_n;
            req_prev <= req_prev_n;
            ack      <= ack_n;
            dout     <= dout_n;
            valid    <= valid_n;
            busy     <= busy_n;
            err      <= err_n;
            cnt      <= cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        req_prev_n = req_prev;
        ack_n      = ack;
        dout_n     = dout;
        valid_n    = valid;
        busy_n     = busy;
        err_n      = err;
        cnt_n      = cnt;
        unique case (state)
            IDLE: begin
                if (req_pend) begin
                    dout_n     = bus.src_data;
                    req_prev_n = req_sync;
                    valid_n    = 1'b1;
                    busy_n     = 1'b1;
                    state_n    = VALID;
                end
            end
            VALID: begin
                // A toggle seen here arrived before our ack went out.
                if (req_pend) begin
                    err_n = 1'b1;
                end
                if (bus.dout_ready) begin
                    ack_n   = ~ack;
                    valid_n = 1'b0;
                    busy_n  = 1'b0;
                    cnt_n   = cnt + 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.dest_ack_tgl = ack;
    assign bus.dout         = dout;
    assign bus.dout_valid   = valid;
    assign bus.busy         = busy;
    assign bus.proto_err    = err;
    assign bus.xfer_cnt     = cnt;
endmodule

// File: tb/tb_cdc_bus_sync_rx.sv
// Directed bench for cdc_bus_sync_rx: default instance plus a
// deep-synchroniser / narrow-counter instance.
module tb_cdc_bus_sync_rx;
    logic dest_clk;
    logic rstn;

    int checks = 0;
    int errors = 0;

    logic [7:0] q  [$];
    logic [7:0] q4 [$];

    cdc_bus_sync_rx_if #(.DATA_W(8), .CNT_W(16)) bus ();
    cdc_bus_sync_rx_if #(.DATA_W(8), .CNT_W(2))  bus4 ();

    cdc_bus_sync_rx #(
        .DATA_W(8), .NUM_OF_FLOPS(2), .CNT_W(16)
    ) dut (
        .dest_clk (dest_clk),
        .rstn     (rstn),
        .bus      (bus.slave)
    );

    cdc_bus_sync_rx #(
        .DATA_W(8), .NUM_OF_FLOPS(4), .CNT_W(2)
    ) dut4 (
        .dest_clk (dest_clk),
        .rstn     (rstn),
        .bus      (bus4.slave)
    );

    initial dest_clk = 1'b0;
    always #5 dest_clk = ~dest_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag, input logic [7:0] obs);
        logic [7:0] exp;
        if (q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(q.size()), 32'd1);
        end else begin
            exp = q.pop_front();
            check(tag, 32'(obs), 32'(exp));
        end
    endtask

    task automatic send(input logic [7:0] d);
        bus.src_data    = d;
        bus.src_req_tgl = ~bus.src_req_tgl;
        q.push_back(d);
    endtask

    task automatic send4(input logic [7:0] d);
        bus4.src_data    = d;
        bus4.src_req_tgl = ~bus4.src_req_tgl;
        q4.push_back(d);
    endtask

    // Counts negedges until dout_valid; returns 99 on timeout.
    task automatic wait_valid(output int n);
        n = 0;
        while (bus.dout_valid !== 1'b1 && n < 20) begin
            @(negedge dest_clk);
            n++;
        end
        if (bus.dout_valid !== 1'b1) n = 99;
    endtask

    task automatic wait_valid4(output int n);
        n = 0;
        while (bus4.dout_valid !== 1'b1 && n < 30) begin
            @(negedge dest_clk);
            n++;
        end
        if (bus4.dout_valid !== 1'b1) n = 99;
    endtask

    initial begin
        int  n;
        bit  stable;
        logic [7:0] e;

        rstn             = 1'b0;
        bus.src_req_tgl  = 1'b0;
        bus.src_data     = '0;
        bus.dout_ready   = 1'b0;
        bus4.src_req_tgl = 1'b0;
        bus4.src_data    = '0;
        bus4.dout_ready  = 1'b0;
        repeat (2) @(negedge dest_clk);
        check("rst_valid", 32'(bus.dout_valid), 32'd0);
        check("rst_ack", 32'(bus.dest_ack_tgl), 32'd0);
        check("rst_dout", 32'(bus.dout), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_err", 32'(bus.proto_err), 32'd0);
        check("rst_cnt", 32'(bus.xfer_cnt), 32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge dest_clk);

        // 1: basic transfer with ready held high
        bus.dout_ready = 1'b1;
        send(8'hA5);
        repeat (2) @(negedge dest_clk);
        check("t1_early_valid", 32'(bus.dout_valid), 32'd0);
        @(negedge dest_clk);
        check("t1_valid", 32'(bus.dout_valid), 32'd1);
        check("t1_busy", 32'(bus.busy), 32'd1);
        check("t1_ack_pre", 32'(bus.dest_ack_tgl), 32'd0);
        pop_check("t1_dout", bus.dout);
        @(negedge dest_clk);
        check("t1_ack", 32'(bus.dest_ack_tgl), 32'd1);
        check("t1_busy_drop", 32'(bus.busy), 32'd0);
        check("t1_valid_drop", 32'(bus.dout_valid), 32'd0);
        check("t1_cnt", 32'(bus.xfer_cnt), 32'd1);

        // 2: backpressure for 10 cycles
        bus.dout_ready = 1'b0;
        send(8'h3C);
        e = 8'h3C;
        wait_valid(n);
        check("t2_latency", 32'(n), 32'd3);
        stable = 1'b1;
        repeat (10) begin
            @(negedge dest_clk);
            if (bus.dout_valid !== 1'b1 || bus.dout !== e ||
                bus.dest_ack_tgl !== 1'b1)
                stable = 1'b0;
        end
        check("t2_stable", 32'(stable), 32'd1);
        pop_check("t2_dout", bus.dout);
        bus.dout_ready = 1'b1;
        @(negedge dest_clk);
        check("t2_ack", 32'(bus.dest_ack_tgl), 32'd0);
        check("t2_cnt", 32'(bus.xfer_cnt), 32'd2);
        @(negedge dest_clk);
        check("t2_ack_once", 32'(bus.dest_ack_tgl), 32'd0);

        // 3: back-to-back legal words from a fresh reset
        rstn = 1'b0;
        bus.src_req_tgl = 1'b0;
        @(negedge dest_clk);
        rstn = 1'b1;
        @(negedge dest_clk);
        for (int i = 0; i < 3; i++) begin
            send(8'(i + 1));
            wait_valid(n);
            check("t3_latency", 32'(n), 32'd3);
            pop_check("t3_dout", bus.dout);
            @(negedge dest_clk);
            check("t3_ack", 32'(bus.dest_ack_tgl), 32'((i + 1) % 2));
        end
        check("t3_cnt", 32'(bus.xfer_cnt), 32'd3);
        check("t3_err", 32'(bus.proto_err), 32'd0);

        // 4: second toggle before ack
        bus.dout_ready = 1'b0;
        send(8'h11);
        wait_valid(n);
        check("t4_latency", 32'(n), 32'd3);
        send(8'h22);
        repeat (2) @(negedge dest_clk);
        check("t4_err_early", 32'(bus.proto_err), 32'd0);
        @(negedge dest_clk);
        check("t4_err", 32'(bus.proto_err), 32'd1);
        pop_check("t4_first", bus.dout);
        bus.dout_ready = 1'b1;
        @(negedge dest_clk);
        bus.dout_ready = 1'b0;
        check("t4_gap", 32'(bus.dout_valid), 32'd0);
        check("t4_ack", 32'(bus.dest_ack_tgl), 32'd0);
        @(negedge dest_clk);
        check("t4_recap", 32'(bus.dout_valid), 32'd1);
        pop_check("t4_second", bus.dout);
        bus.dout_ready = 1'b1;
        @(negedge dest_clk);
        check("t4_ack2", 32'(bus.dest_ack_tgl), 32'd1);
        check("t4_err_sticky", 32'(bus.proto_err), 32'd1);
        check("t4_cnt", 32'(bus.xfer_cnt), 32'd5);

        // 5: async reset while holding a word with ack high
        bus.dout_ready = 1'b0;
        send(8'h5A);
        wait_valid(n);
        check("t5_pre_ack", 32'(bus.dest_ack_tgl), 32'd1);
        #2;
        rstn = 1'b0;
        bus.src_req_tgl = 1'b0;
        void'(q.pop_front());
        #1;
        check("t5_valid", 32'(bus.dout_valid), 32'd0);
        check("t5_ack", 32'(bus.dest_ack_tgl), 32'd0);
        check("t5_dout", 32'(bus.dout), 32'd0);
        check("t5_busy", 32'(bus.busy), 32'd0);
        check("t5_err", 32'(bus.proto_err), 32'd0);
        check("t5_cnt", 32'(bus.xfer_cnt), 32'd0);
        @(negedge dest_clk);
        rstn = 1'b1;
        @(negedge dest_clk);
        bus.dout_ready = 1'b1;
        send(8'h77);
        wait_valid(n);
        check("t5_latency", 32'(n), 32'd3);
        pop_check("t5_dout_new", bus.dout);
        @(negedge dest_clk);
        check("t5_ack_new", 32'(bus.dest_ack_tgl), 32'd1);
        check("t5_cnt_new", 32'(bus.xfer_cnt), 32'd1);

        // 6: four-flop synchroniser, 2-bit counter wrap
        bus4.dout_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send4(8'(8'h40 + i));
            wait_valid4(n);
            check("t6_latency", 32'(n), 32'd5);
            if (q4.size() == 0) begin
                check("t6_sb_empty", 32'(q4.size()), 32'd1);
            end else begin
                e = q4.pop_front();
                check("t6_dout", 32'(bus4.dout), 32'(e));
            end
            @(negedge dest_clk);
            check("t6_cnt", 32'(bus4.xfer_cnt), 32'((i + 1) % 4));
            check("t6_ack", 32'(bus4.dest_ack_tgl), 32'((i + 1) % 2));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
